gmii_rx_frame_check: RTL
========================

Name: gmii_rx_frame_check

Overview:
- Sits directly downstream of the RGMII receive DDR/delay stage, in the gmii_rx_clk domain.
- Consumes the registered GMII byte stream (dv/er/rxd).
- Strips preamble and SFD, checks FCS (CRC-32) and frame length, and removes the 4 FCS bytes.
- Emits a framed byte stream (valid/sop/eop/err) plus per-frame status pulses for MAC logic.

Parameters:
- MIN_LEN, 64, minimum legal post-SFD byte count including FCS.
- MAX_LEN, 1518, maximum legal post-SFD byte count including FCS.
- PRE_MAX, 15, maximum preamble bytes accepted before SFD.

Ports:
- gmii_rx_clk  input  1  receive clock; all logic is on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- gmii_rx_dv  input  1  GMII data valid.
- gmii_rx_er  input  1  GMII receive error.
- gmii_rxd  input  8  GMII receive byte.
- m_data  output  8  payload byte.
- m_valid  output  1  m_data valid; single-cycle strobe per byte, no backpressure.
- m_sop  output  1  first payload byte of frame (qualified by m_valid).
- m_eop  output  1  last payload byte of frame (qualified by m_valid).
- m_err  output  1  frame bad; meaningful only with m_eop.
- stat_good  output  1  one-cycle pulse: frame ended without error.
- stat_crc_err  output  1  one-cycle pulse: FCS mismatch.
- stat_len_err  output  1  one-cycle pulse: runt or oversize.
- stat_phy_err  output  1  one-cycle pulse: gmii_rx_er seen inside frame.

Behaviour:
- Reset (async, active-high): every output is 0, FSM is IDLE, CRC = 0xFFFFFFFF, counters and pipeline are cleared.
- FSM states: IDLE, PREAMBLE, DATA, DROP.
- IDLE:
  - dv=1 with rxd=0x55 -> PREAMBLE, preamble count=1.
  - dv=1 with rxd=0xD5 -> DATA.
  - dv=1 with any other byte -> DROP.
  - er with dv=0 (carrier extension) is ignored.
- PREAMBLE:
  - 0x55 increments the count; count > PRE_MAX -> DROP.
  - 0xD5 -> DATA.
  - Any other byte, or er=1 -> DROP.
  - dv=0 -> IDLE, nothing emitted, no status pulse.
- DATA:
  - Each dv=1 byte enters a 5-stage shift register (s0..s4) and the reflected CRC-32 update (poly 0xEDB88320, LSB-first).
  - The post-SFD byte counter increments per byte and saturates at 2047.
  - When a byte shifts in and fill is already 5, s4 is output registered: m_valid=1 next cycle. m_sop=1 on the first such output of the frame.
  - er=1 in DATA sets a sticky phy_err flag.
- End of frame (dv falls in DATA):
  - The cycle after dv=0, s4 is emitted with m_valid=1 and m_eop=1. s0..s3 hold the FCS and are discarded.
  - crc_ok is CRC register == 0xDEBB20E3 after the FCS bytes.
  - m_err = !crc_ok | phy_err | (count < MIN_LEN).
  - Exactly one status pulse fires, in the same cycle, with priority phy > len > crc; stat_good fires otherwise.
  - The FSM returns to IDLE and the CRC, count and flags are reinitialised.
- Runt with fewer than 5 post-SFD bytes: nothing is emitted and stat_len_err pulses. If only 5 bytes arrived, a single beat carries sop=eop=1, err=1.
- Oversize: the byte that makes count = MAX_LEN+1 forces emission of s4 with m_eop=1 and m_err=1, and stat_len_err pulses. The FSM enters DROP and the remaining bytes are not emitted.
- DROP: ignores all input until dv=0, then -> IDLE. A DROP entered from IDLE/PREAMBLE produces no output and no pulse.
- Back-to-back frames: dv=0 for one cycle between frames is sufficient. The eop beat of frame N and the first preamble byte of frame N+1 may occur in the same cycle.
- Latency: a payload byte appears on m_data 5 input bytes after it enters (4 FCS-hold bytes plus 1 register). eop comes 1 cycle after dv falls.
- Reset mid-frame: output stops immediately, no eop for the aborted frame, and the next frame is received normally.

Test Plan:
- 7x0x55, 0xD5, 60 bytes 0x00..0x3B, correct FCS, dv falls -> exactly 60 m_valid beats 0x00..0x3B; sop on 0x00; eop on 0x3B one cycle after dv=0; m_err=0; stat_good=1 for one cycle.
- Same frame with the last FCS byte XOR 0x01 -> identical data beats, eop with m_err=1, stat_crc_err=1, stat_good=0.
- Correct-FCS frame of 40 payload bytes -> 40 beats, eop with m_err=1, stat_len_err=1. Frame of 1 post-SFD byte -> no beats, stat_len_err=1.
- 1600-byte frame with MAX_LEN=1518 -> first 1514 payload bytes emitted, eop with m_err=1 on byte 1514, stat_len_err=1, no further beats until the next frame.
- 0x55, 0x55, 0xA5, then 70 bytes -> no output, no pulse. gmii_rx_er=1 on payload byte 10 of a 64-byte frame -> eop with m_err=1, stat_phy_err=1.
- rst asserted for 2 cycles at payload byte 20, then a good 64-byte frame -> no eop for the aborted frame; the second frame yields 60 beats and stat_good=1.

Source files
------------

// File: rtl/gmii_rx_frame_check.sv
// GMII receive frame checker.
// Strips preamble/SFD from the registered GMII byte stream, holds the
// trailing four bytes back so the FCS is never forwarded, checks CRC-32,
// frame length and PHY errors, and emits a framed byte stream plus one
// status pulse per completed frame.
module gmii_rx_frame_check #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518,
    parameter int PRE_MAX = 15
) (
    input  logic       gmii_rx_clk,
    input  logic       rst,
    input  logic       gmii_rx_dv,
    input  logic       gmii_rx_er,
    input  logic [7:0] gmii_rxd,
    output logic [7:0] m_data,
    output logic       m_valid,
    output logic       m_sop,
    output logic       m_eop,
    output logic       m_err,
    output logic       stat_good,
    output logic       stat_crc_err,
    output logic       stat_len_err,
    output logic       stat_phy_err
);

    localparam int          PW          = $clog2(PRE_MAX + 2);
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
    localparam logic [10:0] CNT_SAT     = 11'd2047;
    localparam logic [10:0] LEN_MIN     = 11'(MIN_LEN);
    localparam logic [10:0] LEN_OVER    = 11'(MAX_LEN + 1);
    localparam logic [7:0]  PRE_BYTE    = 8'h55;
    localparam logic [7:0]  SFD_BYTE    = 8'hD5;
    localparam logic [2:0]  FILL_FULL   = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_DATA     = 2'd2,
        ST_DROP     = 2'd3
    } state_t;

    // Reflected CRC-32 (poly 0xEDB88320), one byte, LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            c = (c[0] ^ d[i]) ? ({1'b0, c[31:1]} ^ 32'hEDB8_8320) : {1'b0, c[31:1]};
        end
        return c;
    endfunction

    state_t          state_r, state_s;
    logic [PW-1:0]   pre_cnt_r, pre_cnt_s, pre_inc_s;
    logic [31:0]     crc_r, crc_s, crc_upd_s;
    logic [10:0]     cnt_r, cnt_s, cnt_inc_s;
    logic [2:0]      fill_r, fill_s;
    logic [4:0][7:0] sh_r, sh_s;             // sh[0] newest byte, sh[4] next to emit
    logic            phy_err_r, phy_err_s;
    logic            sop_done_r, sop_done_s;
    logic            crc_ok_s, runt_s;
    logic [7:0]      data_s;
    logic            valid_s, sop_s, eop_s, err_s;
    logic            good_s, crc_err_s, len_err_s, phy_pulse_s;

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_s     = state_r;
        pre_cnt_s   = pre_cnt_r;
        crc_s       = crc_r;
        cnt_s       = cnt_r;
        fill_s      = fill_r;
        sh_s        = sh_r;
        phy_err_s   = phy_err_r;
        sop_done_s  = sop_done_r;
        data_s      = m_data;
        valid_s     = 1'b0;
        sop_s       = 1'b0;
        eop_s       = 1'b0;
        err_s       = 1'b0;
        good_s      = 1'b0;
        crc_err_s   = 1'b0;
        len_err_s   = 1'b0;
        phy_pulse_s = 1'b0;
        pre_inc_s   = pre_cnt_r + PW'(1);
        crc_upd_s   = crc32_byte(crc_r, gmii_rxd);
        cnt_inc_s   = (cnt_r == CNT_SAT) ? cnt_r : cnt_r + 11'd1;
        crc_ok_s    = (crc_r == CRC_RESIDUE);
        runt_s      = (cnt_r < LEN_MIN);

        case (state_r)
            ST_IDLE: begin
                if (gmii_rx_dv) begin
                    if (gmii_rxd == PRE_BYTE) begin
                        state_s   = ST_PREAMBLE;
                        pre_cnt_s = PW'(1);
                    end else if (gmii_rxd == SFD_BYTE) begin
                        state_s = ST_DATA;
                    end else begin
                        state_s = ST_DROP;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PREAMBLE: begin
                if (!gmii_rx_dv) begin
                    state_s = ST_IDLE;
                end else if (gmii_rx_er) begin
                    state_s = ST_DROP;
                end else if (gmii_rxd == PRE_BYTE) begin
                    pre_cnt_s = pre_inc_s;
                    state_s   = (pre_inc_s > PW'(PRE_MAX)) ? ST_DROP : ST_PREAMBLE;
                end else if (gmii_rxd == SFD_BYTE) begin
                    state_s = ST_DATA;
                end else begin
                    state_s = ST_DROP;
                end
            end
            ST_DATA: begin
                if (gmii_rx_dv) begin
                    sh_s      = {sh_r[3:0], gmii_rxd};
                    crc_s     = crc_upd_s;
                    cnt_s     = cnt_inc_s;
                    fill_s    = (fill_r == FILL_FULL) ? fill_r : fill_r + 3'd1;
                    phy_err_s = phy_err_r | gmii_rx_er;
                    if (fill_r == FILL_FULL) begin
                        valid_s    = 1'b1;
                        data_s     = sh_r[4];
                        sop_s      = !sop_done_r;
                        sop_done_s = 1'b1;
                    end else begin
                        valid_s = 1'b0;
                    end
                    // Oversize: close the frame on the held byte and discard the rest.
                    if (cnt_inc_s == LEN_OVER) begin
                        eop_s      = 1'b1;
                        err_s      = 1'b1;
                        len_err_s  = 1'b1;
                        state_s    = ST_DROP;
                        crc_s      = CRC_INIT;
                        cnt_s      = 11'd0;
                        fill_s     = 3'd0;
                        phy_err_s  = 1'b0;
                        sop_done_s = 1'b0;
                    end else begin
                        state_s = ST_DATA;
                    end
                end else begin
                    // dv fell: s0..s3 are the FCS, s4 is the last payload byte.
                    if (fill_r == FILL_FULL) begin
                        valid_s = 1'b1;
                        data_s  = sh_r[4];
                        sop_s   = !sop_done_r;
                        eop_s   = 1'b1;
                        err_s   = !crc_ok_s | phy_err_r | runt_s;
                    end else begin
                        valid_s = 1'b0;
                    end
                    if (phy_err_r) begin
                        phy_pulse_s = 1'b1;
                    end else if (runt_s) begin
                        len_err_s = 1'b1;
                    end else if (!crc_ok_s) begin
                        crc_err_s = 1'b1;
                    end else begin
                        good_s = 1'b1;
                    end
                    state_s    = ST_IDLE;
                    crc_s      = CRC_INIT;
                    cnt_s      = 11'd0;
                    fill_s     = 3'd0;
                    phy_err_s  = 1'b0;
                    sop_done_s = 1'b0;
                end
            end
            ST_DROP: begin
                state_s = gmii_rx_dv ? ST_DROP : ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, frame context and output registers.
    always_ff @(posedge gmii_rx_clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            pre_cnt_r    <= '0;
            crc_r        <= CRC_INIT;
            cnt_r        <= 11'd0;
            fill_r       <= 3'd0;
            sh_r         <= '0;
            phy_err_r    <= 1'b0;
            sop_done_r   <= 1'b0;
            m_data       <= 8'd0;
            m_valid      <= 1'b0;
            m_sop        <= 1'b0;
            m_eop        <= 1'b0;
            m_err        <= 1'b0;
            stat_good    <= 1'b0;
            stat_crc_err <= 1'b0;
            stat_len_err <= 1'b0;
            stat_phy_err <= 1'b0;
        end else begin
            state_r      <= state_s;
            pre_cnt_r    <= pre_cnt_s;
            crc_r        <= crc_s;
            cnt_r        <= cnt_s;
            fill_r       <= fill_s;
            sh_r         <= sh_s;
            phy_err_r    <= phy_err_s;
            sop_done_r   <= sop_done_s;
            m_data       <= data_s;
            m_valid      <= valid_s;
            m_sop        <= sop_s;
            m_eop        <= eop_s;
            m_err        <= err_s;
            stat_good    <= good_s;
            stat_crc_err <= crc_err_s;
            stat_len_err <= len_err_s;
            stat_phy_err <= phy_pulse_s;
        end
    end

endmodule
